// File: rtl/regfile_seq_pkg.sv
// Shared encodings for the register-file command sequencer.
package regfile_seq_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    FS_CLR  = 2'b00,
    FS_LOAD = 2'b01,
    FS_DEC  = 2'b10,
    FS_INC  = 2'b11
  } funsel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic       id;
    funsel_e    op;
    logic [3:0] rsel;
    logic [3:0] tsel;
    logic [7:0] imm;
  } cmd_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer remembers the last accepted requester.
module rr_arbiter2 (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] Valid,
  input  logic       Accept,
  output logic [1:0] Grant
);

  logic last_q, last_d;

  always_comb begin
    Grant = 2'b00;
    unique case (Valid)
      2'b01:   Grant = 2'b01;
      2'b10:   Grant = 2'b10;
      2'b11:   Grant = last_q ? 2'b01 : 2'b10;
      default: Grant = 2'b00;
    endcase
    last_d = last_q;
    if (Accept) last_d = Grant[1];
  end

  // Reset to "requester 1 went last" so requester 0 wins the first tie.
  always_ff @(posedge Clock) begin
    if (!Reset) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Arbitrates two requesters and replays the accepted register-file op Count+1 cycles.
module regfile_sequencer
  import regfile_seq_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Req0Valid,
  input  logic       Req1Valid,
  output logic       Req0Ready,
  output logic       Req1Ready,
  input  logic [1:0] Req0Op,
  input  logic [1:0] Req1Op,
  input  logic [3:0] Req0RSel,
  input  logic [3:0] Req1RSel,
  input  logic [3:0] Req0TSel,
  input  logic [3:0] Req1TSel,
  input  logic [7:0] Req0Imm,
  input  logic [7:0] Req1Imm,
  input  logic [3:0] Req0Count,
  input  logic [3:0] Req1Count,
  output logic [1:0] FunSel,
  output logic [3:0] RSel,
  output logic [3:0] TSel,
  output logic [7:0] I,
  output logic       Busy,
  output logic       Done,
  output logic       DoneId
);

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       grant;
  logic             idle;
  logic             accept;

  assign idle      = (state_q == ST_IDLE);
  assign accept    = idle && Reset && (grant != 2'b00);
  assign Req0Ready = idle && Reset && grant[0];
  assign Req1Ready = idle && Reset && grant[1];

  rr_arbiter2 u_arb (
    .Clock  (Clock),
    .Reset  (Reset),
    .Valid  ({Req1Valid, Req0Valid}),
    .Accept (accept),
    .Grant  (grant)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    FunSel  = '0;
    RSel    = '0;
    TSel    = '0;
    I       = '0;
    Busy    = (state_q != ST_IDLE);
    Done    = 1'b0;
    DoneId  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (grant[1]) begin
            cmd_d = '{id: 1'b1, op: funsel_e'(Req1Op), rsel: Req1RSel, tsel: Req1TSel, imm: Req1Imm};
            cnt_d = Req1Count;
          end else begin
            cmd_d = '{id: 1'b0, op: funsel_e'(Req0Op), rsel: Req0RSel, tsel: Req0TSel, imm: Req0Imm};
            cnt_d = Req0Count;
          end
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        FunSel = cmd_q.op;
        RSel   = cmd_q.rsel;
        TSel   = cmd_q.tsel;
        I      = cmd_q.imm;
        // Exit on zero rather than decrementing, so the counter never wraps.
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_DONE: begin
        Done    = 1'b1;
        DoneId  = cmd_q.id;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed scoreboard bench for regfile_sequencer with a small register-file model.
module tb_regfile_sequencer;
  import regfile_seq_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Req0Valid = 1'b0, Req1Valid = 1'b0;
  logic       Req0Ready, Req1Ready;
  logic [1:0] Req0Op = '0, Req1Op = '0;
  logic [3:0] Req0RSel = '0, Req1RSel = '0, Req0TSel = '0, Req1TSel = '0;
  logic [7:0] Req0Imm = '0, Req1Imm = '0;
  logic [3:0] Req0Count = '0, Req1Count = '0;
  logic [1:0] FunSel;
  logic [3:0] RSel, TSel;
  logic [7:0] I;
  logic       Busy, Done, DoneId;

  regfile_sequencer dut (
    .Clock(Clock), .Reset(Reset),
    .Req0Valid(Req0Valid), .Req1Valid(Req1Valid),
    .Req0Ready(Req0Ready), .Req1Ready(Req1Ready),
    .Req0Op(Req0Op), .Req1Op(Req1Op),
    .Req0RSel(Req0RSel), .Req1RSel(Req1RSel),
    .Req0TSel(Req0TSel), .Req1TSel(Req1TSel),
    .Req0Imm(Req0Imm), .Req1Imm(Req1Imm),
    .Req0Count(Req0Count), .Req1Count(Req1Count),
    .FunSel(FunSel), .RSel(RSel), .TSel(TSel), .I(I),
    .Busy(Busy), .Done(Done), .DoneId(DoneId)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic       id;
    logic [1:0] op;
    logic [3:0] rs;
    logic [3:0] ts;
    logic [7:0] imm;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exec_cnt = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;
  logic expect_abort = 1'b0;
  logic [7:0] rm [4] = '{default: 8'h00};
  logic [7:0] tm [4] = '{default: 8'h00};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [7:0] apply(input logic [1:0] fs, input logic [7:0] v, input logic [7:0] d);
    case (fs)
      2'b00:   return 8'h00;
      2'b01:   return d;
      2'b10:   return v - 8'd1;
      default: return v + 8'd1;
    endcase
  endfunction

  // Register file fed by the DUT outputs; mask bit3 selects R1/T1, bit0 R4/T4.
  always @(posedge Clock) begin
    if (Reset === 1'b1) begin
      for (int k = 0; k < 4; k++) begin
        if (RSel[3-k] === 1'b1) rm[k] <= apply(FunSel, rm[k], I);
        if (TSel[3-k] === 1'b1) tm[k] <= apply(FunSel, tm[k], I);
      end
    end
  end

  always @(negedge Clock) begin
    check("one_ready", 32'(Req0Ready & Req1Ready), 0);
    check("ready_without_valid", 32'({Req1Ready & ~Req1Valid, Req0Ready & ~Req0Valid}), 0);
    if (Reset === 1'b0) check("ready_in_reset", 32'({Req1Ready, Req0Ready}), 0);
    if (Busy === 1'b1) check("ready_while_busy", 32'({Req1Ready, Req0Ready}), 0);
    if (Busy === 1'b1 && Done === 1'b0) begin
      exec_cnt++;
      check("exec_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check("exec_funsel", 32'(FunSel), 32'(exp_q[0].op));
        check("exec_rsel", 32'(RSel), 32'(exp_q[0].rs));
        check("exec_tsel", 32'(TSel), 32'(exp_q[0].ts));
        check("exec_imm", 32'(I), 32'(exp_q[0].imm));
        check("exec_doneid", 32'(DoneId), 0);
      end
    end else if (Done === 1'b1) begin
      check("done_expected", 32'(exp_q.size() != 0), 1);
      check("done_busy", 32'(Busy), 1);
      check("done_outputs_zero", 32'({FunSel, RSel, TSel, I}), 0);
      if (exp_q.size() != 0) begin
        check("done_id", 32'(DoneId), 32'(exp_q[0].id));
        check("exec_length", 32'(exec_cnt), 32'(exp_q[0].cnt) + 1);
        void'(exp_q.pop_front());
      end
      exec_cnt = 0;
      done_cnt++;
    end else if (Busy === 1'b0) begin
      check("idle_outputs_zero", 32'({FunSel, RSel, TSel, I, DoneId}), 0);
      if (exec_cnt != 0) begin
        check("abort_expected", 32'(expect_abort), 1);
        check("abort_length", 32'(exec_cnt), 2);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exec_cnt = 0;
        expect_abort = 1'b0;
      end
    end
    if (prev_done) check("idle_after_done", 32'(Busy), 0);
    prev_done = (Done === 1'b1);
  end

  task automatic set_req(input logic id, input logic [1:0] op, input logic [3:0] rs,
                         input logic [3:0] ts, input logic [7:0] imm, input logic [3:0] cnt);
    if (id) begin
      Req1Op = op; Req1RSel = rs; Req1TSel = ts; Req1Imm = imm; Req1Count = cnt;
    end else begin
      Req0Op = op; Req0RSel = rs; Req0TSel = ts; Req0Imm = imm; Req0Count = cnt;
    end
  endtask

  task automatic push_exp(input logic id, input logic [1:0] op, input logic [3:0] rs,
                          input logic [3:0] ts, input logic [7:0] imm, input logic [3:0] cnt);
    exp_t e;
    e = '{id, op, rs, ts, imm, cnt};
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(done_cnt >= target), 1);
  endtask

  task automatic run_cmd(input string tag, input logic id, input logic [1:0] op, input logic [3:0] rs,
                         input logic [3:0] ts, input logic [7:0] imm, input logic [3:0] cnt);
    int target;
    set_req(id, op, rs, ts, imm, cnt);
    push_exp(id, op, rs, ts, imm, cnt);
    target = done_cnt + 1;
    if (id) Req1Valid = 1'b1; else Req0Valid = 1'b1;
    #1;
    check({tag, "_ready"}, 32'({Req1Ready, Req0Ready}), id ? 2 : 1);
    tick();
    Req0Valid = 1'b0;
    Req1Valid = 1'b0;
    check({tag, "_exec_next"}, 32'({Busy, Done}), 2);
    wait_done(target, 40, tag);
    check({tag, "_idle"}, 32'(Busy), 0);
  endtask

  initial begin
    int target;
    logic [7:0] t4_before;

    tick();
    tick();
    check("reset_outputs", 32'({FunSel, RSel, TSel, I}), 0);
    check("reset_status", 32'({Busy, Done, DoneId, Req0Ready, Req1Ready}), 0);
    Reset = 1'b1;
    tick();

    run_cmd("load_r1", 1'b0, FS_LOAD, 4'b1000, 4'b0000, 8'h5A, 4'd0);
    check("r1_loaded", 32'(rm[0]), 32'h5A);

    t4_before = tm[3];
    run_cmd("inc_t4", 1'b1, FS_INC, 4'b0000, 4'b0001, 8'h00, 4'd3);
    check("t4_plus4", 32'(tm[3]), 32'(t4_before + 8'd4));

    run_cmd("noop", 1'b1, FS_LOAD, 4'b0000, 4'b0000, 8'h77, 4'd2);
    check("noop_r1_kept", 32'(rm[0]), 32'h5A);

    // Valid withdrawn before the edge: no acceptance, pointer untouched.
    Req0Valid = 1'b1;
    #1;
    check("pulse_ready", 32'({Req1Ready, Req0Ready}), 1);
    Req0Valid = 1'b0;
    tick();
    check("pulse_no_accept", 32'(Busy), 0);
    Req0Valid = 1'b1; Req1Valid = 1'b1;
    #1;
    check("pointer_kept", 32'({Req1Ready, Req0Ready}), 1);
    Req0Valid = 1'b0; Req1Valid = 1'b0;
    tick();
    check("probe_no_accept", 32'(Busy), 0);
    run_cmd("req1_only", 1'b1, FS_LOAD, 4'b0000, 4'b0010, 8'h44, 4'd0);
    check("t3_loaded", 32'(tm[2]), 32'h44);

    set_req(1'b0, FS_LOAD, 4'b0001, 4'b0000, 8'h11, 4'd0);
    set_req(1'b1, FS_LOAD, 4'b0010, 4'b0000, 8'h22, 4'd0);
    for (int k = 0; k < 4; k++)
      push_exp(k[0], FS_LOAD, k[0] ? 4'b0010 : 4'b0001, 4'b0000, k[0] ? 8'h22 : 8'h11, 4'd0);
    target = done_cnt + 4;
    Req0Valid = 1'b1; Req1Valid = 1'b1;
    wait_done(target, 60, "alternate");
    Req0Valid = 1'b0; Req1Valid = 1'b0;
    tick();
    check("alt_idle", 32'(Busy), 0);
    check("alt_regs", 32'({rm[2], rm[3]}), 32'h2211);

    set_req(1'b0, FS_INC, 4'b0000, 4'b1000, 8'h00, 4'd7);
    push_exp(1'b0, FS_INC, 4'b0000, 4'b1000, 8'h00, 4'd7);
    Req0Valid = 1'b1;
    #1;
    check("abort_cmd_ready", 32'({Req1Ready, Req0Ready}), 1);
    tick();
    Req0Valid = 1'b0;
    tick();
    Reset = 1'b0;
    expect_abort = 1'b1;
    tick();
    check("abort_masks_zero", 32'({RSel, TSel}), 0);
    check("abort_idle", 32'({Busy, Done}), 0);
    Reset = 1'b1;
    set_req(1'b0, FS_CLR, 4'b1000, 4'b0000, 8'h00, 4'd0);
    set_req(1'b1, FS_INC, 4'b1111, 4'b1111, 8'h00, 4'd0);
    push_exp(1'b0, FS_CLR, 4'b1000, 4'b0000, 8'h00, 4'd0);
    target = done_cnt + 1;
    Req0Valid = 1'b1; Req1Valid = 1'b1;
    #1;
    check("reset_tie_req0", 32'({Req1Ready, Req0Ready}), 1);
    tick();
    Req0Valid = 1'b0; Req1Valid = 1'b0;
    wait_done(target, 40, "after_reset");
    check("r1_cleared", 32'(rm[0]), 0);

    set_req(1'b1, FS_DEC, 4'b0100, 4'b0000, 8'h33, 4'd15);
    push_exp(1'b1, FS_DEC, 4'b0100, 4'b0000, 8'h33, 4'd15);
    target = done_cnt + 1;
    Req1Valid = 1'b1;
    #1;
    check("count15_ready", 32'({Req1Ready, Req0Ready}), 2);
    tick();
    Req1Valid = 1'b0;
    repeat (3) tick();
    set_req(1'b1, FS_INC, 4'b1111, 4'b1111, 8'hFF, 4'd0);
    Req0Valid = 1'b1; Req1Valid = 1'b1;
    #1;
    check("busy_ignores_valid", 32'({Req1Ready, Req0Ready}), 0);
    repeat (4) tick();
    Req0Valid = 1'b0; Req1Valid = 1'b0;
    wait_done(target, 40, "count15");
    check("r2_dec16", 32'(rm[1]), 32'hF0);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 SHALL have port Clock, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous active-low reset sampled on the rising edge of Clock.
REQ-003 SHALL have ports Req0Valid and Req1Valid, input, 1 each, requester command valid.
REQ-004 SHALL have ports Req0Ready and Req1Ready, input-side handshake outputs, 1 each; a command is accepted when Valid and Ready are high on the same edge.
REQ-005 SHALL have ports Req0Op and Req1Op, input, 2, op code: 00 clear, 01 load, 10 decrement, 11 increment.
REQ-006 SHALL have ports Req0RSel, Req1RSel, Req0TSel and Req1TSel, input, 4 each, target masks with bit3 = R1/T1 and bit0 = R4/T4.
REQ-007 SHALL have ports Req0Imm and Req1Imm, input, 8 each, load value.
REQ-008 SHALL have ports Req0Count and Req1Count, input, 4 each; the op is applied Count+1 consecutive cycles.
REQ-009 SHALL have port FunSel, output, 2, the op code driven to the register file.
REQ-010 SHALL have ports RSel and TSel, output, 4 each, write masks driven to the register file.
REQ-011 SHALL have port I, output, 8, the load data driven to the register file.
REQ-012 SHALL have port Busy, output, 1, high in every state other than IDLE.
REQ-013 SHALL have port Done, output, 1, a one-cycle completion pulse.
REQ-014 SHALL have port DoneId, output, 1, the requester index that owned the completed command.

Function
REQ-015 SHALL implement the FSM states IDLE, EXEC and DONE.
REQ-016 In IDLE, the granted requester's Ready SHALL be high; only one Ready SHALL ever be high; the Ready of a requester whose Valid is low SHALL be low.
REQ-017 Arbitration SHALL be round-robin; with both Valid high, grant the requester not granted last; with one Valid high, grant it.
REQ-018 On acceptance, the sequencer SHALL latch Op, RSel, TSel, Imm, Count and the requester id; load a 4-bit repeat counter with Count; go IDLE->EXEC.
REQ-019 In EXEC, the outputs SHALL drive FunSel=Op, RSel, TSel and I=Imm from the latched values; each cycle the counter SHALL decrement; at counter==0 the FSM SHALL go EXEC->DONE.
REQ-020 Timing SHALL be: accept at edge N, EXEC cycles N+1..N+1+Count, Done high in cycle N+2+Count, IDLE with Ready available in cycle N+3+Count.
REQ-021 Outside EXEC, RSel and TSel SHALL be 0000, FunSel SHALL be 00 and I SHALL be 00h, so no register is modified.
REQ-022 Count=0 SHALL give exactly 1 EXEC cycle; Count=15 SHALL give exactly 16 EXEC cycles; the counter SHALL never wrap.
REQ-023 RSel=TSel=0000 SHALL still sequence normally as a timed no-op and still pulse Done.
REQ-024 A Valid dropped before acceptance SHALL cause no grant and no change to the round-robin pointer.
REQ-025 Requester inputs SHALL be ignored outside IDLE; the latched command SHALL be stable through EXEC.
REQ-026 The round-robin pointer SHALL update only on acceptance.
REQ-027 Done and DoneId SHALL be asserted only in DONE.

Reset
REQ-028 While Reset=0 at an edge, the state SHALL go to IDLE, the counter SHALL be 0 and the pointer SHALL be set so that requester 0 wins the first tie.
REQ-029 Reset values SHALL be: FunSel=00, RSel=0000, TSel=0000, I=00h, Busy=0, Done=0, DoneId=0, Req0Ready=0, Req1Ready=0.
REQ-030 A reset asserted mid-EXEC SHALL zero the masks from the next edge, with no Done issued for the aborted command.

Structure
REQ-031 Package regfile_seq_pkg SHALL hold the FunSel encodings (CLR, LOAD, DEC, INC), the state encoding and the 4-bit count width constant.
REQ-032 The two-way round-robin grant logic SHALL be the sub-module rr_arbiter2 (inputs Valid[1:0] and Accept; output Grant[1:0]).
REQ-033 The implementation target SHALL be roughly 150-250 lines of RTL.

Verification
REQ-034 Scenario: Req0 with Op=01, RSel=1000, Imm=5Ah, Count=0 -> one EXEC cycle with FunSel=01, RSel=1000, I=5Ah; Done with DoneId=0 two cycles after accept.
REQ-035 Scenario: Req1 with Op=11, TSel=0001, Count=3 -> exactly 4 EXEC cycles with TSel=0001; a register file model shows T4 incremented by 4.
REQ-036 Scenario: both requesters valid continuously, Count=0 -> grants alternate 0,1,0,1 and DoneId alternates the same way.
REQ-037 Scenario: Reset=0 in the 2nd EXEC cycle of a Count=7 command -> RSel/TSel=0000 from the next edge, no Done, and requester 0 wins the next tie.
REQ-038 Scenario: Req0 Valid pulsed low before Ready -> no accept; a subsequent Req1-only request is granted immediately.
